// File: rtl/mult_result_accumulator.sv
// -----------------------------------------------------------------------------
// mult_result_accumulator
//
// Takes the block-read stream from the multiplier and reduces it. A start
// request sends a one-cycle EN_blockRead pulse to the multiplier. The block
// then collects NUM_WORDS products and keeps a running sum, a running maximum
// and a word count. The finished result goes downstream through a
// VALID_result / RDY_result handshake. If the multiplier stops sending words
// for TIMEOUT_CYC cycles, the block is aborted and the partial result is
// reported with result_timeout set.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            asynchronous reset, active low
//   EN_start       start request, taken only while RDY_start=1
//   RDY_start      high in IDLE (decoded from state)
//   EN_blockRead   one-cycle block-read request to the multiplier
//   VALID_memVal   product word valid, from the multiplier
//   memVal_data    product word, unsigned
//   result_sum     sum of collected words, modulo 2^ACC_W
//   result_max     largest collected word
//   result_count   number of words collected
//   result_ovf     sticky accumulator carry-out
//   result_timeout block aborted by the inactivity timeout
//   VALID_result   result registers valid
//   RDY_result     consumer accepts the result
// -----------------------------------------------------------------------------
module mult_result_accumulator #(
  parameter int DATA_W      = 32,
  parameter int ACC_W       = 40,
  parameter int NUM_WORDS   = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN_start,
  output logic              RDY_start,
  output logic              EN_blockRead,
  input  logic              VALID_memVal,
  input  logic [DATA_W-1:0] memVal_data,
  output logic [ACC_W-1:0]  result_sum,
  output logic [DATA_W-1:0] result_max,
  output logic [6:0]        result_count,
  output logic              result_ovf,
  output logic              result_timeout,
  output logic              VALID_result,
  input  logic              RDY_result
);

  // The counter only has to hold 0..TIMEOUT_CYC-1. The terminal value is
  // detected one step early, and that same edge leaves COLLECT.
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt;

  logic             start_accept;
  logic             take_word;
  logic             tmo_hit;
  logic [ACC_W:0]   sum_ext;
  logic [6:0]       count_next;

  assign RDY_start  = (state_q == IDLE);
  // One extra bit on the accumulator captures the carry-out for result_ovf.
  assign sum_ext    = {1'b0, result_sum} + (ACC_W+1)'(memVal_data);
  assign count_next = result_count + 7'd1;

  // ---------------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    state_d      = state_q;
    start_accept = 1'b0;
    take_word    = 1'b0;
    tmo_hit      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (EN_start) begin
          start_accept = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: state_d = COLLECT;
      COLLECT: begin
        if (VALID_memVal) begin
          take_word = 1'b1;
          if (count_next == 7'(NUM_WORDS)) state_d = DONE;
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          tmo_hit = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (RDY_result) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, handshake outputs and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. That way every
  // register samples the values from before the edge, whatever order the
  // statements are written in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      EN_blockRead   <= 1'b0;
      VALID_result   <= 1'b0;
      result_sum     <= '0;
      result_max     <= '0;
      result_count   <= '0;
      result_ovf     <= 1'b0;
      result_timeout <= 1'b0;
      tmo_cnt        <= '0;
    end else begin
      state_q      <= state_d;
      // The pulse and the valid flag are registered copies of the next state,
      // so they line up exactly with REQ and DONE.
      EN_blockRead <= (state_d == REQ);
      VALID_result <= (state_d == DONE);

      if (start_accept) begin
        result_sum     <= '0;
        result_max     <= '0;
        result_count   <= '0;
        result_ovf     <= 1'b0;
        result_timeout <= 1'b0;
        tmo_cnt        <= '0;
      end

      if (take_word) begin
        result_sum   <= sum_ext[ACC_W-1:0];
        result_ovf   <= result_ovf | sum_ext[ACC_W];
        result_count <= count_next;
        tmo_cnt      <= '0;
        if (memVal_data > result_max) result_max <= memVal_data;
      end else if (state_q == COLLECT) begin
        if (tmo_hit) result_timeout <= 1'b1;
        else         tmo_cnt        <= tmo_cnt + TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mult_result_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mult_result_accumulator
//
// Directed bench for mult_result_accumulator. It uses three instances:
//   a: NUM_WORDS=9, TIMEOUT_CYC=16   - main stream, gaps, ignored inputs, reset
//   b: NUM_WORDS=4, TIMEOUT_CYC=16   - inactivity timeout
//   c: NUM_WORDS=8, ACC_W=34         - accumulator carry-out
// Inputs change 1 time unit after a rising edge. Outputs are checked at the
// same point.
// -----------------------------------------------------------------------------
module tb_mult_result_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- instance a ----------------
  logic        en_a = 0, vld_a = 0, rdy_a = 0;
  logic [31:0] dat_a = '0;
  logic        rdys_a, blk_a, ovf_a, tmo_a, vres_a;
  logic [39:0] sum_a;
  logic [31:0] max_a;
  logic [6:0]  cnt_a;

  mult_result_accumulator #(.DATA_W(32), .ACC_W(40), .NUM_WORDS(9), .TIMEOUT_CYC(16)) dut_a (
    .clk(clk), .rst(rst), .EN_start(en_a), .RDY_start(rdys_a), .EN_blockRead(blk_a),
    .VALID_memVal(vld_a), .memVal_data(dat_a), .result_sum(sum_a), .result_max(max_a),
    .result_count(cnt_a), .result_ovf(ovf_a), .result_timeout(tmo_a),
    .VALID_result(vres_a), .RDY_result(rdy_a));

  // ---------------- instance b ----------------
  logic        en_b = 0, vld_b = 0, rdy_b = 0;
  logic [31:0] dat_b = '0;
  logic        rdys_b, blk_b, ovf_b, tmo_b, vres_b;
  logic [39:0] sum_b;
  logic [31:0] max_b;
  logic [6:0]  cnt_b;

  mult_result_accumulator #(.DATA_W(32), .ACC_W(40), .NUM_WORDS(4), .TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .rst(rst), .EN_start(en_b), .RDY_start(rdys_b), .EN_blockRead(blk_b),
    .VALID_memVal(vld_b), .memVal_data(dat_b), .result_sum(sum_b), .result_max(max_b),
    .result_count(cnt_b), .result_ovf(ovf_b), .result_timeout(tmo_b),
    .VALID_result(vres_b), .RDY_result(rdy_b));

  // ---------------- instance c ----------------
  logic        en_c = 0, vld_c = 0, rdy_c = 0;
  logic [31:0] dat_c = '0;
  logic        rdys_c, blk_c, ovf_c, tmo_c, vres_c;
  logic [33:0] sum_c;
  logic [31:0] max_c;
  logic [6:0]  cnt_c;

  mult_result_accumulator #(.DATA_W(32), .ACC_W(34), .NUM_WORDS(8), .TIMEOUT_CYC(1024)) dut_c (
    .clk(clk), .rst(rst), .EN_start(en_c), .RDY_start(rdys_c), .EN_blockRead(blk_c),
    .VALID_memVal(vld_c), .memVal_data(dat_c), .result_sum(sum_c), .result_max(max_c),
    .result_count(cnt_c), .result_ovf(ovf_c), .result_timeout(tmo_c),
    .VALID_result(vres_c), .RDY_result(rdy_c));

  // Count block-read pulses seen by the multiplier side of instance a.
  int pulses_a = 0;
  always @(posedge clk) if (blk_a) pulses_a <= pulses_a + 1;

  logic [31:0] words [9] = '{32'd9, 32'd16, 32'd21, 32'd24, 32'd25, 32'd24, 32'd21, 32'd16, 32'd9};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic start_a();
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
  endtask

  // Stream the nine words into instance a, with 'gap' idle cycles after each.
  task automatic stream_a(input int gap);
    for (int i = 0; i < 9; i++) begin
      vld_a = 1'b1;
      dat_a = words[i];
      tick();
      vld_a = 1'b0;
      if (i < 8) repeat (gap) tick();
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    #2;
    check("rst_rdy_start", 64'(rdys_a), 64'd1);
    check("rst_blk",       64'(blk_a),  64'd0);
    check("rst_vres",      64'(vres_a), 64'd0);
    check("rst_sum",       64'(sum_a),  64'd0);
    check("rst_cnt",       64'(cnt_a),  64'd0);
    tick();
    rst = 1'b1;
    tick();

    // ---------------- a: contiguous stream ----------------
    start_a();
    check("t1_blk_pulse", 64'(blk_a),  64'd1);
    check("t1_rdy_start", 64'(rdys_a), 64'd0);
    tick();
    check("t1_blk_low",   64'(blk_a),  64'd0);
    for (int i = 0; i < 8; i++) begin
      vld_a = 1'b1; dat_a = words[i]; tick();
    end
    check("t1_vres_early", 64'(vres_a), 64'd0);
    dat_a = words[8]; tick();
    vld_a = 1'b0;
    check("t1_vres", 64'(vres_a), 64'd1);
    check("t1_sum",  64'(sum_a),  64'd165);
    check("t1_max",  64'(max_a),  64'd25);
    check("t1_cnt",  64'(cnt_a),  64'd9);
    check("t1_ovf",  64'(ovf_a),  64'd0);
    check("t1_tmo",  64'(tmo_a),  64'd0);
    check("t1_pulses", 64'(pulses_a), 64'd1);
    rdy_a = 1'b1; tick(); rdy_a = 1'b0;
    check("t1_idle_rdy",  64'(rdys_a), 64'd1);
    check("t1_idle_vres", 64'(vres_a), 64'd0);
    check("t1_held_sum",  64'(sum_a),  64'd165);

    // ---------------- a: gapped stream, EN_start abuse ----------------
    start_a();
    tick();
    vld_a = 1'b1; dat_a = words[0]; tick(); vld_a = 1'b0;
    check("t2_cleared_cnt", 64'(cnt_a), 64'd1);
    en_a = 1'b1; tick(); en_a = 1'b0; tick();           // start during COLLECT
    for (int i = 1; i < 9; i++) begin
      vld_a = 1'b1; dat_a = words[i]; tick(); vld_a = 1'b0;
      if (i < 8) begin tick(); tick(); end
    end
    check("t2_vres", 64'(vres_a), 64'd1);
    for (int i = 0; i < 5; i++) begin
      en_a = (i == 2);                                  // start during DONE
      vld_a = (i == 3); dat_a = 32'd1000;               // valid during DONE
      tick();
      check("t2_hold_vres", 64'(vres_a), 64'd1);
      check("t2_hold_sum",  64'(sum_a),  64'd165);
    end
    en_a = 1'b0; vld_a = 1'b0;
    check("t2_max", 64'(max_a), 64'd25);
    check("t2_cnt", 64'(cnt_a), 64'd9);
    // Accept and start together: start must be dropped.
    rdy_a = 1'b1; en_a = 1'b1; tick(); rdy_a = 1'b0; en_a = 1'b0;
    check("t2_idle_rdy",  64'(rdys_a), 64'd1);
    check("t2_idle_vres", 64'(vres_a), 64'd0);
    vld_a = 1'b1; dat_a = 32'd500; tick(); tick(); vld_a = 1'b0;
    check("t2_idle_rdy2",   64'(rdys_a),   64'd1);
    check("t2_idle_sum",    64'(sum_a),    64'd165);
    check("t2_idle_cnt",    64'(cnt_a),    64'd9);
    check("t2_pulses",      64'(pulses_a), 64'd2);

    // ---------------- b: timeout ----------------
    en_b = 1'b1; tick(); en_b = 1'b0;
    tick();
    vld_b = 1'b1; dat_b = 32'd7; tick();
    dat_b = 32'd3; tick();
    vld_b = 1'b0;
    repeat (15) tick();
    check("t3_vres_early", 64'(vres_b), 64'd0);
    tick();
    check("t3_vres", 64'(vres_b), 64'd1);
    check("t3_tmo",  64'(tmo_b),  64'd1);
    check("t3_cnt",  64'(cnt_b),  64'd2);
    check("t3_sum",  64'(sum_b),  64'd10);
    check("t3_max",  64'(max_b),  64'd7);
    rdy_b = 1'b1; tick(); rdy_b = 1'b0;
    check("t3_idle_rdy", 64'(rdys_b), 64'd1);

    // ---------------- c: accumulator carry-out ----------------
    en_c = 1'b1; tick(); en_c = 1'b0;
    tick();
    vld_c = 1'b1; dat_c = 32'hFFFF_FFFF;
    repeat (8) tick();
    vld_c = 1'b0;
    check("t4_vres", 64'(vres_c), 64'd1);
    check("t4_sum",  64'(sum_c),  64'h3_FFFF_FFF8);
    check("t4_ovf",  64'(ovf_c),  64'd1);
    check("t4_max",  64'(max_c),  64'hFFFF_FFFF);
    check("t4_cnt",  64'(cnt_c),  64'd8);
    rdy_c = 1'b1; tick(); rdy_c = 1'b0;

    // ---------------- a: reset mid-COLLECT ----------------
    start_a();
    tick();
    for (int i = 0; i < 3; i++) begin
      vld_a = 1'b1; dat_a = words[i]; tick();
    end
    check("t5_mid_cnt", 64'(cnt_a), 64'd3);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_sum",  64'(sum_a),  64'd0);
    check("t5_rst_max",  64'(max_a),  64'd0);
    check("t5_rst_cnt",  64'(cnt_a),  64'd0);
    check("t5_rst_vres", 64'(vres_a), 64'd0);
    check("t5_rst_rdy",  64'(rdys_a), 64'd1);
    tick();
    rst = 1'b1;
    tick();                                             // words still arriving
    vld_a = 1'b0;
    check("t5_ignored_cnt", 64'(cnt_a), 64'd0);
    start_a();
    tick();
    stream_a(0);
    check("t5_vres", 64'(vres_a), 64'd1);
    check("t5_sum",  64'(sum_a),  64'd165);
    check("t5_cnt",  64'(cnt_a),  64'd9);
    rdy_a = 1'b1; tick(); rdy_a = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_result_accumulator.md
Name: mult_result_accumulator

Overview:
- Downstream consumer of the multiplier's block-read stream.
- On command, pulses EN_blockRead to the multiplier, then collects NUM_WORDS products from VALID_memVal/memVal_data.
- While collecting, it builds a running sum, a running maximum and a word count.
- It presents the result to a downstream consumer through a valid/ready handshake. It feeds the team's reduction/readout path.

Parameters:
DATA_W, 32, width of memVal_data (product width)
ACC_W, 40, width of result_sum accumulator
NUM_WORDS, 64, products per block read (multiplier memory depth); legal range 1..64
TIMEOUT_CYC, 1024, max consecutive cycles without VALID_memVal in COLLECT before abort; legal range >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
EN_start  input  1  start request; accepted only when RDY_start=1
RDY_start  output  1  high in IDLE only
EN_blockRead  output  1  one-cycle pulse to the multiplier requesting a block read
VALID_memVal  input  1  product word valid, from the multiplier
memVal_data  input  DATA_W  product word, unsigned
result_sum  output  ACC_W  sum of collected words
result_max  output  DATA_W  largest collected word
result_count  output  7  number of words collected
result_ovf  output  1  sticky: accumulator carry-out occurred
result_timeout  output  1  block aborted by timeout
VALID_result  output  1  result registers valid
RDY_result  input  1  consumer accepts result

Behaviour:
- Reset (rst=0, async): state=IDLE; EN_blockRead=0; VALID_result=0; result_sum=0; result_max=0; result_count=0; result_ovf=0; result_timeout=0; timeout counter=0. RDY_start=1 follows from IDLE.
- All outputs are registered, except RDY_start, which is decoded from state.
- States: IDLE, REQ, COLLECT, DONE.
- IDLE:
  - RDY_start=1.
  - EN_start=1 -> REQ next cycle.
  - On the same edge, clear result_sum, result_max, result_count, result_ovf, result_timeout and the timeout counter.
- REQ:
  - EN_blockRead=1 for exactly this one cycle; next state is COLLECT unconditionally.
  - VALID_memVal during REQ is ignored.
- COLLECT, on each cycle with VALID_memVal=1:
  - result_sum <= result_sum + zero-extended memVal_data, wrapping mod 2^ACC_W; carry-out sets result_ovf (sticky).
  - result_max <= max(result_max, memVal_data), unsigned compare.
  - result_count increments; timeout counter clears.
  - If this word makes result_count reach NUM_WORDS -> DONE. Latency from final valid word to VALID_result=1 is 1 cycle.
- COLLECT, on each cycle with VALID_memVal=0:
  - Timeout counter increments.
  - When it reaches TIMEOUT_CYC -> DONE with result_timeout=1; partial sum, max and count are kept.
- DONE:
  - VALID_result=1; all result_* outputs are held stable.
  - RDY_result=1 -> IDLE next cycle, with VALID_result=0. Results stay readable (held) in IDLE until the next accepted EN_start.
- Ignored inputs:
  - EN_start outside IDLE is ignored (not queued).
  - VALID_memVal in IDLE, REQ or DONE is ignored: no state change, no accumulation.
- DONE with RDY_result=1 and EN_start=1 in the same cycle: EN_start is ignored because RDY_start=0.
- Back-to-back blocks: after DONE->IDLE, EN_start is accepted in the first IDLE cycle. Minimum period between EN_blockRead pulses is NUM_WORDS+3 cycles with continuous valids.
- Reset asserted mid-COLLECT: immediate return to IDLE with all outputs cleared; any remaining multiplier words are ignored.
- NUM_WORDS=1: a single valid word moves COLLECT to DONE.
- ACC_W < DATA_W+6 is legal; overflow is reported via result_ovf, not saturated.

Test Plan:
- Reset, then NUM_WORDS=9, EN_start pulse; stream 9,16,21,24,25,24,21,16,9 one per cycle -> one EN_blockRead pulse 1 cycle after start; VALID_result=1 one cycle after the last word, with result_sum=165, result_max=25, result_count=9, result_ovf=0, result_timeout=0.
- Same stream with VALID_memVal gapped (valid every 3rd cycle) and RDY_result held low 5 cycles -> identical results; VALID_result and the outputs stay stable until RDY_result=1, then IDLE and RDY_start=1 next cycle.
- NUM_WORDS=4, TIMEOUT_CYC=16; send 2 words (7,3), then silence -> DONE 16 cycles after the last valid, with result_timeout=1, result_count=2, result_sum=10, result_max=7.
- ACC_W=34, NUM_WORDS=8; send 8 × 32'hFFFFFFFF -> result_sum=(8×(2^32−1)) mod 2^34 = 34'h3FFFFFFF8, result_ovf=1, result_max=32'hFFFFFFFF.
- EN_start pulsed during COLLECT and DONE, and VALID_memVal pulsed in IDLE -> no extra EN_blockRead, no accumulation, counts unchanged.
- Assert rst low after 3 of 9 words in COLLECT -> all outputs 0 asynchronously, state IDLE; a fresh EN_start and full stream then give result_sum=165.
